// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one external combinational ALU between two requesters.
// Optional macro ALU_SCHED_CFLAG_EN: per-requester carry flag feeds alu_cin instead of reqN_cin.
module alu_scheduler #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [3:0]           req0_opcode,
    input  logic [BUS_WIDTH-1:0] req0_a,
    input  logic [BUS_WIDTH-1:0] req0_b,
    input  logic                 req0_cin,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [3:0]           req1_opcode,
    input  logic [BUS_WIDTH-1:0] req1_a,
    input  logic [BUS_WIDTH-1:0] req1_b,
    input  logic                 req1_cin,
    output logic [3:0]           alu_opcode,
    output logic [BUS_WIDTH-1:0] alu_a,
    output logic [BUS_WIDTH-1:0] alu_b,
    output logic                 alu_cin,
    input  logic [BUS_WIDTH-1:0] alu_y,
    input  logic                 alu_cout,
    input  logic                 alu_borrow,
    input  logic                 alu_zero,
    input  logic                 alu_parity,
    input  logic                 alu_invalid_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [BUS_WIDTH-1:0] rsp_y,
    output logic                 rsp_cout,
    output logic                 rsp_borrow,
    output logic                 rsp_zero,
    output logic                 rsp_parity,
    output logic                 rsp_invalid,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t               state_q, state_d;
    logic                 last_grant_q;
    logic [3:0]           op_q;
    logic [BUS_WIDTH-1:0] a_q, b_q;
    logic                 id_q;
    logic                 grant_any, grant_id, exec;

    // On a tie the requester that was not served last wins.
    assign grant_any = req0_valid | req1_valid;
    assign grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign exec      = (state_q == EXEC);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = grant_any && !grant_id;
                req1_ready = grant_any &&  grant_id;
                if (grant_any) state_d = EXEC;
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_y        <= '0;
            rsp_cout     <= 1'b0;
            rsp_borrow   <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_parity   <= 1'b0;
            rsp_invalid  <= 1'b0;
        end else begin
            if (state_q == IDLE && grant_any) begin
                last_grant_q <= grant_id;
                id_q         <= grant_id;
                op_q         <= grant_id ? req1_opcode : req0_opcode;
                a_q          <= grant_id ? req1_a : req0_a;
                b_q          <= grant_id ? req1_b : req0_b;
            end
            if (exec) begin
                rsp_id      <= id_q;
                rsp_y       <= alu_y;
                rsp_cout    <= alu_cout;
                rsp_borrow  <= alu_borrow;
                rsp_zero    <= alu_zero;
                rsp_parity  <= alu_parity;
                rsp_invalid <= alu_invalid_op;
            end
        end
    end

`ifdef ALU_SCHED_CFLAG_EN
    logic [1:0] cflag_q, cflag_d;
    logic       unused_cin;

    assign unused_cin = req0_cin ^ req1_cin;
    assign alu_cin    = exec & cflag_q[id_q];

    // Only ADD/ADD_CARRY/SUB touch the carry chain of the issuing requester.
    always_comb begin
        cflag_d = cflag_q;
        if (exec) begin
            if (op_q == 4'd1 || op_q == 4'd2) cflag_d[id_q] = alu_cout;
            else if (op_q == 4'd3)            cflag_d[id_q] = alu_borrow;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cflag_q <= '0;
        else        cflag_q <= cflag_d;
    end
`else
    logic cin_q;

    assign alu_cin = exec & cin_q;

    always_ff @(posedge clk) begin
        if (!rst_n)                              cin_q <= 1'b0;
        else if (state_q == IDLE && grant_any)   cin_q <= grant_id ? req1_cin : req0_cin;
    end
`endif

    assign alu_opcode = exec ? op_q : 4'd0;
    assign alu_a      = exec ? a_q : '0;
    assign alu_b      = exec ? b_q : '0;
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: models the external ALU, checks every cycle against a transaction model.
module tb_alu_scheduler;
    typedef struct packed {
        logic [7:0] y;
        logic cout, borrow, zero, parity, inv;
    } res_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       req0_valid = 0, req1_valid = 0, req0_cin = 0, req1_cin = 0;
    logic [3:0] req0_opcode = 0, req1_opcode = 0;
    logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic       req0_ready, req1_ready;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a, alu_b, alu_y, rsp_y;
    logic       alu_cin, alu_cout, alu_borrow, alu_zero, alu_parity, alu_invalid_op;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_id;
    logic       rsp_cout, rsp_borrow, rsp_zero, rsp_parity, rsp_invalid, busy;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    alu_scheduler #(.BUS_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_borrow(alu_borrow), .alu_zero(alu_zero),
        .alu_parity(alu_parity), .alu_invalid_op(alu_invalid_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .rsp_cout(rsp_cout), .rsp_borrow(rsp_borrow), .rsp_zero(rsp_zero),
        .rsp_parity(rsp_parity), .rsp_invalid(rsp_invalid), .busy(busy)
    );

    function automatic res_t alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic cin);
        res_t r;
        int   s;
        r = '0;
        s = 0;
        case (op)
            4'd1: begin s = int'(a) + int'(b);            r.y = s[7:0]; r.cout = (s > 255); end
            4'd2: begin s = int'(a) + int'(b) + int'(cin); r.y = s[7:0]; r.cout = (s > 255); end
            4'd3: begin r.y = a - b; r.borrow = (a < b); end
            4'd4: begin r.y = a + 8'd1; r.cout = (a == 8'hFF); end
            4'd5: begin r.y = a - 8'd1; r.borrow = (a == 8'h00); end
            4'd6: r.y = a & b;
            4'd7: r.y = ~a;
            4'd8: r.y = {a[6:0], a[7]};
            4'd9: r.y = {a[0], a[7:1]};
            default: r.inv = 1'b1;
        endcase
        r.zero   = (r.y == 8'd0);
        r.parity = ^r.y;
        return r;
    endfunction

    res_t alu_r;
    always_comb alu_r = alu_f(alu_opcode, alu_a, alu_b, alu_cin);
    assign alu_y          = alu_r.y;
    assign alu_cout       = alu_r.cout;
    assign alu_borrow     = alu_r.borrow;
    assign alu_zero       = alu_r.zero;
    assign alu_parity     = alu_r.parity;
    assign alu_invalid_op = alu_r.inv;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Transaction-level model: one op in flight, aged in cycles since acceptance.
    bit         m_pend = 0, m_last = 1;
    int         m_age = 0;
    bit   [1:0] m_cflag = '0;
    logic [3:0] t_op;
    logic [7:0] t_a, t_b;
    logic       t_cin, t_id;
    res_t       t_res, m_rsp = '0;
    logic       m_rsp_id = 0;

    always @(negedge clk) begin
        logic e_r0, e_r1, e_exec;
        logic [7:0] e_ya;
        e_r0   = !m_pend && req0_valid && (!req1_valid || m_last);
        e_r1   = !m_pend && req1_valid && (!req0_valid || !m_last);
        e_exec = m_pend && (m_age == 0);
        chk("ready", {req1_ready, req0_ready}, {e_r1, e_r0});
        chk("busy", busy, m_pend);
        chk("rsp_valid", rsp_valid, m_pend && m_age >= 1);
        chk("alu_drive", {alu_opcode, alu_a, alu_b, alu_cin},
            e_exec ? {t_op, t_a, t_b, t_cin} : 21'd0);
        chk("rsp_fields", {rsp_id, rsp_y, rsp_cout, rsp_borrow, rsp_zero, rsp_parity, rsp_invalid},
            {m_rsp_id, m_rsp});
        e_ya = 0;
        if (!rst_n) begin
            m_pend = 0; m_last = 1; m_cflag = '0; m_rsp = '0; m_rsp_id = 0;
        end else if (!m_pend) begin
            if (e_r0 || e_r1) begin
                t_id = e_r1;
                t_op = t_id ? req1_opcode : req0_opcode;
                t_a  = t_id ? req1_a : req0_a;
                t_b  = t_id ? req1_b : req0_b;
`ifdef ALU_SCHED_CFLAG_EN
                t_cin = m_cflag[t_id];
`else
                t_cin = t_id ? req1_cin : req0_cin;
`endif
                t_res  = alu_f(t_op, t_a, t_b, t_cin);
                m_last = t_id;
                m_pend = 1;
                m_age  = 0;
            end
        end else if (m_age == 0) begin
            m_rsp    = t_res;
            m_rsp_id = t_id;
            if (t_op == 4'd1 || t_op == 4'd2) m_cflag[t_id] = t_res.cout;
            else if (t_op == 4'd3)           m_cflag[t_id] = t_res.borrow;
            m_age = 1;
        end else if (rsp_ready) begin
            m_pend = 0;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input bit id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic cin);
        if (id) begin req1_valid = 1; req1_opcode = op; req1_a = a; req1_b = b; req1_cin = cin; end
        else    begin req0_valid = 1; req0_opcode = op; req0_a = a; req0_b = b; req0_cin = cin; end
    endtask

    task automatic do_op(input string nm, input bit id, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic [7:0] ey);
        int n;
        set_req(id, op, a, b, cin);
        rsp_ready = 1;
        n = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk({nm, "_grant_timeout"}, 0, 1);
        step();
        req0_valid = 0; req1_valid = 0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk({nm, "_latency"}, n, 1);
        chk({nm, "_y"}, rsp_y, ey);
        chk({nm, "_id"}, rsp_id, id);
        step();
    endtask

    task automatic do_reset();
        rst_n = 0; req0_valid = 0; req1_valid = 0;
        step(); step();
        rst_n = 1;
    endtask

    initial begin
        do_reset();
        repeat (2) begin
            @(negedge clk);
            chk("idle_outputs", {busy, rsp_valid, alu_opcode, rsp_y, rsp_invalid}, 0);
            step();
        end

        do_op("add", 0, 4'd1, 8'd9, 8'd33, 1'b0, 8'd42);
        chk("add_zero", rsp_zero, 0);

        // contention + backpressure
        do_reset();
        rsp_ready = 0;
        set_req(0, 4'd3, 8'd9, 8'd33, 1'b0);
        set_req(1, 4'd3, 8'd33, 8'd9, 1'b0);
        @(negedge clk);
        chk("tie_grant", {req1_ready, req0_ready}, 2'b01);
        step();
        req0_valid = 0;
        step();
        repeat (4) begin
            @(negedge clk);
            chk("bp_hold", {rsp_valid, rsp_id, rsp_y, rsp_borrow, req1_ready}, {2'b10, 8'd232, 2'b10});
            step();
        end
        rsp_ready = 1;
        step();
        @(negedge clk);
        chk("second_grant", req1_ready, 1);
        step();
        req1_valid = 0;
        step();
        @(negedge clk);
        chk("sub_req1", {rsp_valid, rsp_id, rsp_y}, {2'b11, 8'd24});
        step();

        // carry chain
        do_reset();
        do_op("chain_add", 0, 4'd1, 8'd200, 8'd100, 1'b0, 8'd44);
        chk("chain_cout", rsp_cout, 1);
`ifdef ALU_SCHED_CFLAG_EN
        do_op("chain_r1", 1, 4'd2, 8'd1, 8'd1, 1'b1, 8'd2);
`else
        do_op("chain_r1", 1, 4'd2, 8'd1, 8'd1, 1'b1, 8'd3);
`endif
        do_op("chain_r0", 0, 4'd2, 8'd1, 8'd1, 1'b1, 8'd3);

        // invalid opcode keeps cflag
        do_op("pre_add", 1, 4'd1, 8'd200, 8'd100, 1'b0, 8'd44);
        do_op("invalid", 1, 4'd0, 8'd5, 8'd6, 1'b0, 8'd0);
        chk("invalid_flag", rsp_invalid, 1);
        do_op("post_inv", 1, 4'd2, 8'd24, 8'd53, 1'b1, 8'd78);

        // reset during EXEC
        set_req(0, 4'd1, 8'd200, 8'd100, 1'b0);
        @(negedge clk);
        step();
        req0_valid = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            chk("midop_reset", {rsp_valid, busy}, 2'b00);
            step();
        end
        do_op("after_reset", 0, 4'd2, 8'd1, 8'd1, 1'b0, 8'd2);

        // randomized traffic, checked by the model every cycle
        repeat (1500) begin
            rst_n       = ($urandom % 100) != 0;
            req0_valid  = $urandom % 2;
            req1_valid  = $urandom % 2;
            req0_opcode = 4'($urandom_range(0, 15));
            req1_opcode = 4'($urandom_range(0, 15));
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_cin = 1'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_cin = 1'($urandom);
            rsp_ready = ($urandom % 3) != 0;
            step();
        end
        rst_n = 1; req0_valid = 0; req1_valid = 0;
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
